// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with PC, imem handshake and skid-backed output
//
// Purpose:
//   Owns the program counter, issues word fetches to instruction memory over a
//   req/ack handshake, and presents {pc, instruction} to decode through a
//   valid/ready output register backed by a one-entry skid buffer. Branch
//   redirects flush the stage; a fetch that is still outstanding when a
//   redirect arrives is drained and its data discarded.
//
// Ports:
//   clk         system clock, rising edge
//   clrn        asynchronous active-low reset
//   imem_req    fetch request to instruction memory
//   imem_addr   byte address of the request, [1:0] = 00
//   imem_ack    memory returns data this cycle (ignored while imem_req = 0)
//   imem_rdata  instruction word, valid when imem_req & imem_ack
//   br_taken    redirect pulse from execute, highest priority
//   br_target   redirect address, [1:0] forced to 00
//   id_valid    id_pc / id_inst hold a valid instruction
//   id_ready    decode accepts this cycle
//   id_pc       PC of the presented instruction
//   id_inst     presented instruction
//   pc_out      current fetch PC register

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] pc_out
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] drain_addr, drain_addr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic [31:0] skid_inst, skid_inst_n;
  logic        valid_n;
  logic [31:0] id_pc_n, id_inst_n;
  logic        out_free;
  logic [31:0] pc_inc;
  logic [31:0] br_pc;

  // Gated by clrn so the request drops the instant reset is asserted,
  // even though the state register itself resets to FETCH.
  assign imem_req  = clrn && (state != ST_HOLD);
  // While draining, the abandoned request's address must stay on the bus
  // until memory acks it; pc has already moved to the redirect target.
  assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc;
  assign pc_out    = pc;

  assign out_free = !id_valid || id_ready;
  assign pc_inc   = pc + 32'd4;
  assign br_pc    = br_target & 32'hFFFF_FFFC;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drain_addr_n = drain_addr;
    skid_pc_n    = skid_pc;
    skid_inst_n  = skid_inst;
    valid_n      = id_valid;
    id_pc_n      = id_pc;
    id_inst_n    = id_inst;

    if (br_taken) begin
      pc_n        = br_pc;
      valid_n     = 1'b0;
      id_inst_n   = NOP_INST;
      skid_pc_n   = 32'h0;
      skid_inst_n = NOP_INST;
      case (state)
        ST_FETCH: begin
          if (!imem_ack) begin
            // Request stays outstanding: remember its address and drain it.
            state_n      = ST_DRAIN;
            drain_addr_n = pc;
          end else begin
            state_n = ST_FETCH;
          end
        end
        ST_HOLD:  state_n = ST_FETCH;
        ST_DRAIN: state_n = imem_ack ? ST_FETCH : ST_DRAIN;
        default:  state_n = ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            pc_n = pc_inc;
            if (out_free) begin
              id_pc_n   = pc;
              id_inst_n = imem_rdata;
              valid_n   = 1'b1;
            end else begin
              // Decode is stalled: park the word and stop requesting.
              skid_pc_n   = pc;
              skid_inst_n = imem_rdata;
              state_n     = ST_HOLD;
            end
          end else if (id_ready) begin
            valid_n = 1'b0;
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            id_pc_n   = skid_pc;
            id_inst_n = skid_inst;
            valid_n   = 1'b1;
            state_n   = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // Data returned here belongs to the flushed path and is dropped.
          if (imem_ack) begin
            state_n = ST_FETCH;
          end
        end
        default: state_n = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_FETCH;
      pc         <= PC_RST;
      drain_addr <= 32'h0;
      skid_pc    <= 32'h0;
      skid_inst  <= NOP_INST;
      id_valid   <= 1'b0;
      id_pc      <= 32'h0;
      id_inst    <= NOP_INST;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drain_addr <= drain_addr_n;
      skid_pc    <= skid_pc_n;
      skid_inst  <= skid_inst_n;
      id_valid   <= valid_n;
      id_pc      <= id_pc_n;
      id_inst    <= id_inst_n;
    end
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the pipelined CPU.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Delivers {pc, instruction} to the decode stage through a single-entry valid/ready output register backed by a one-entry skid buffer.
- Accepts taken-branch/jump redirects from downstream and flushes any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INST, 32'h0000_0000, value driven on id_inst while reset or flushed.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clrn  input  1  asynchronous active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  word address of the request (byte address, [1:0]=00).
imem_ack  input  1  memory has returned data this cycle; ignored when imem_req=0.
imem_rdata  input  32  instruction word, valid when imem_req & imem_ack.
br_taken  input  1  redirect pulse from execute; highest priority.
br_target  input  32  redirect address; bits [1:0] forced to 00 internally.
id_valid  output  1  id_pc/id_inst hold a valid instruction.
id_ready  input  1  decode accepts this cycle; transfer = id_valid & id_ready.
id_pc  output  32  PC of the presented instruction.
id_inst  output  32  presented instruction.
pc_out  output  32  current fetch PC register (debug/monitor).

Behaviour:
- Reset (clrn=0, async):
  - pc=RESET_PC, state=FETCH, id_valid=0, id_pc=0, id_inst=NOP_INST, skid empty.
  - imem_req=0 while clrn=0; first request is issued in the first cycle after release.
- States: FETCH, HOLD, DRAIN.
- Outputs by state:
  - FETCH: imem_req=1.
  - DRAIN: imem_req=1.
  - HOLD: imem_req=0.
  - imem_addr=pc in FETCH. In DRAIN, imem_addr holds the address of the outstanding request, stored in an internal register.
- Handshake rules:
  - Once imem_req rises, it and imem_addr stay stable until the cycle imem_ack=1.
  - Zero-wait ack (same cycle as req) is legal and gives one instruction per cycle.
- FETCH, on ack without redirect:
  - Output free (id_valid=0 or id_ready=1): id_inst<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4, stay FETCH.
  - Output stalled (id_valid=1, id_ready=0): skid<=imem_rdata/pc, pc<=pc+4, go HOLD.
- FETCH without ack: if id_ready=1, id_valid<=0 after transfer; otherwise outputs hold.
- HOLD, when id_ready=1: output register<=skid, id_valid stays 1, go FETCH. Outputs are frozen while id_ready=0.
- Output stability: id_pc/id_inst/id_valid never change while id_valid=1 and id_ready=0, except on flush.
- Redirect (br_taken=1, any state), overriding all of the above:
  - pc<={br_target[31:2],2'b00}.
  - id_valid<=0, id_inst<=NOP_INST, skid cleared.
  - Next state:
    - FETCH with imem_ack=0 → DRAIN (request still outstanding).
    - FETCH with imem_ack=1 → data discarded, stay FETCH.
    - HOLD → FETCH.
    - DRAIN with imem_ack=0 → stay DRAIN, pc updated to newest target.
    - DRAIN with imem_ack=1 → FETCH.
- DRAIN: keep the old request until ack, discard imem_rdata, then go FETCH and request the redirected pc the next cycle. No instruction is delivered from DRAIN.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 → 32'h0000_0000, no flag.
- Redirect latency: first request to the target is issued the cycle after br_taken (FETCH case). The target instruction appears on id_* one cycle after its ack.
- Reset asserted mid-request: all state is cleared immediately and imem_req drops asynchronously. The memory must tolerate the abandoned request.

Test Plan:
- Reset then streaming: clrn released, imem_ack=1 every cycle, id_ready=1 → id_pc sequence 0,4,8,C on consecutive cycles with id_inst=mem[pc]; pc_out leads id_pc by 4.
- Wait states: ack delayed 2 cycles per request → imem_addr stable over 3 cycles each; id_valid pulses every 3 cycles; no duplicated or skipped pc.
- Backpressure: id_ready=0 for 4 cycles while fetching pc=8 then C → id_pc=8 frozen, state HOLD with skid pc=C, imem_req=0; on id_ready=1, id_pc=C next cycle, then fetch resumes at 10.
- Redirect during wait: request to pc=14 outstanding, br_taken with br_target=32'h0000_0103 → DRAIN; after ack, data discarded, next imem_addr=32'h0000_0100, id_valid=0 until its ack.
- Redirect in HOLD and back-to-back redirects: br_taken in HOLD → id_valid=0, skid dropped, next fetch at target. Two br_taken in DRAIN (targets 40 then 80) → fetch resumes at 80.
- Wrap and async reset: pc=FFFF_FFFC fetched → next imem_addr=0000_0000. clrn pulsed low mid-request → imem_req=0 and id_valid=0 immediately, restart at RESET_PC.
